// File: rtl/seven_seg_scan_driver_if.sv
// Software-facing bundle of the seven-segment scan driver: shadow writes, commit,
// brightness/blanking controls, plus the board pins and status strobes it returns.
interface seven_seg_scan_driver_if #(
   parameter int NUM_DIGITS = 8,
   parameter int BRIGHT_W   = 4
);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   logic                  wr_en;
   logic [IDX_W-1:0]      wr_idx;
   logic                  wr_mode;
   logic [7:0]            wr_data;
   logic                  wr_dp;
   logic                  commit;
   logic [BRIGHT_W-1:0]   brightness;
   logic [NUM_DIGITS-1:0] blank_mask;

   logic [NUM_DIGITS-1:0] an_n;
   logic [6:0]            seg_n;
   logic                  dp_n;
   logic                  commit_pend;
   logic                  commit_done;
   logic                  frame_start;

   modport master (
      output wr_en, wr_idx, wr_mode, wr_data, wr_dp, commit, brightness, blank_mask,
      input  an_n, seg_n, dp_n, commit_pend, commit_done, frame_start
   );

   modport slave (
      input  wr_en, wr_idx, wr_mode, wr_data, wr_dp, commit, brightness, blank_mask,
      output an_n, seg_n, dp_n, commit_pend, commit_done, frame_start
   );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: double-buffered glyph store committed at frame
// boundaries, one-anode-at-a-time scan with PWM brightness and hex/ASCII decode.
module seven_seg_scan_driver #(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 64,
   parameter int BRIGHT_W   = 4
) (
   input logic                    i_clk,
   input logic                    i_rst_n,
   seven_seg_scan_driver_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_DIGITS);
   localparam int IDX_W1 = IDX_W + 1;
   localparam int PRE_W  = $clog2(PRESCALE);

   localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE - 1);
   localparam logic [IDX_W-1:0]  DIG_LAST  = IDX_W'(NUM_DIGITS - 1);
   localparam logic [IDX_W1-1:0] DIG_COUNT = IDX_W1'(NUM_DIGITS);

   typedef struct packed {
      logic       mode;
      logic [7:0] data;
      logic       dp;
   } entry_t;

   localparam entry_t BLANK_ENTRY = '{mode: 1'b1, data: 8'h20, dp: 1'b0};

   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h7E;
         4'h1:    seg = 7'h30;
         4'h2:    seg = 7'h6D;
         4'h3:    seg = 7'h79;
         4'h4:    seg = 7'h33;
         4'h5:    seg = 7'h5B;
         4'h6:    seg = 7'h5F;
         4'h7:    seg = 7'h70;
         4'h8:    seg = 7'h7F;
         4'h9:    seg = 7'h73;
         4'hA:    seg = 7'h77;
         4'hB:    seg = 7'h1F;
         4'hC:    seg = 7'h0D;
         4'hD:    seg = 7'h3D;
         4'hE:    seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return seg;
   endfunction

   // Codes 0x30-0x3F reuse the hex glyphs: '0'-'9' then A b c d E F for 0x3A-0x3F.
   function automatic logic [6:0] ascii_to_seg(input logic [7:0] code);
      logic [6:0] seg;
      seg = 7'h00;
      if (code[7:4] == 4'h3) begin
         seg = hex_to_seg(code[3:0]);
      end else begin
         case (code)
            8'h2D:   seg = 7'h01;
            8'h41:   seg = 7'h77;
            8'h61:   seg = 7'h7D;
            8'h62:   seg = 7'h1F;
            8'h43:   seg = 7'h4E;
            8'h63:   seg = 7'h0D;
            8'h64:   seg = 7'h3D;
            8'h45:   seg = 7'h4F;
            8'h46:   seg = 7'h47;
            8'h47:   seg = 7'h5E;
            8'h48:   seg = 7'h37;
            8'h68:   seg = 7'h17;
            8'h49:   seg = 7'h06;
            8'h4A:   seg = 7'h3C;
            8'h4C:   seg = 7'h0E;
            8'h6E:   seg = 7'h15;
            8'h4F:   seg = 7'h7E;
            8'h6F:   seg = 7'h1D;
            8'h50:   seg = 7'h67;
            8'h71:   seg = 7'h73;
            8'h72:   seg = 7'h05;
            8'h53:   seg = 7'h5B;
            8'h74:   seg = 7'h0F;
            8'h55:   seg = 7'h3E;
            8'h75:   seg = 7'h1C;
            8'h79:   seg = 7'h3B;
            default: seg = 7'h00;
         endcase
      end
      return seg;
   endfunction

   logic [PRE_W-1:0]      r_pre_cnt;
   logic [BRIGHT_W-1:0]   r_tick_cnt;
   logic [IDX_W-1:0]      r_dig_idx;
   logic                  r_commit_pend;
   logic                  r_commit_done;
   logic                  r_frame_start;
   logic [NUM_DIGITS-1:0] r_an_n;
   logic [6:0]            r_seg_n;
   logic                  r_dp_n;
   entry_t                r_shadow [NUM_DIGITS];
   entry_t                r_active [NUM_DIGITS];

   logic                  w_tick;
   logic                  w_period_end;
   logic                  w_wrap;
   logic                  w_copy;
   logic                  w_wr_ok;
   logic                  w_lit;
   entry_t                w_entry;
   entry_t                w_wr_entry;
   logic [6:0]            w_glyph;

   assign w_tick       = (r_pre_cnt == PRE_LAST);
   assign w_period_end = w_tick && (r_tick_cnt == '1);
   assign w_wrap       = w_period_end && (r_dig_idx == DIG_LAST);
   assign w_copy       = w_wrap && r_commit_pend;
   assign w_wr_ok      = bus.wr_en && ({1'b0, bus.wr_idx} < DIG_COUNT);
   assign w_wr_entry   = '{mode: bus.wr_mode, data: bus.wr_data, dp: bus.wr_dp};

   always_comb begin
      w_entry = r_active[r_dig_idx];
      w_glyph = w_entry.mode ? ascii_to_seg(w_entry.data) : hex_to_seg(w_entry.data[3:0]);
      w_lit   = (r_tick_cnt < bus.brightness) && !bus.blank_mask[r_dig_idx];
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pre_cnt  <= '0;
         r_tick_cnt <= '0;
         r_dig_idx  <= '0;
      end else begin
         r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PRE_W'(1);
         if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + BRIGHT_W'(1);
         end
         if (w_period_end) begin
            r_dig_idx <= w_wrap ? '0 : r_dig_idx + IDX_W'(1);
         end
      end
   end

   // A commit arriving in the copy cycle re-arms the request for the following frame.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_commit_pend <= 1'b0;
         r_commit_done <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_commit_pend <= (r_commit_pend && !w_copy) || bus.commit;
         r_commit_done <= w_copy;
         r_frame_start <= w_wrap;
      end
   end

   // The copy reads the shadow before this edge's write lands, so a same-cycle write waits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            r_shadow[i] <= BLANK_ENTRY;
            r_active[i] <= BLANK_ENTRY;
         end
      end else begin
         if (w_copy) begin
            r_active <= r_shadow;
         end
         if (w_wr_ok) begin
            r_shadow[bus.wr_idx] <= w_wr_entry;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_an_n  <= '1;
         r_seg_n <= 7'h7F;
         r_dp_n  <= 1'b1;
      end else begin
         r_an_n  <= w_lit ? ~(NUM_DIGITS'(1) << r_dig_idx) : '1;
         r_seg_n <= w_lit ? ~w_glyph : 7'h7F;
         r_dp_n  <= ~(w_lit && w_entry.dp);
      end
   end

   assign bus.an_n        = r_an_n;
   assign bus.seg_n       = r_seg_n;
   assign bus.dp_n        = r_dp_n;
   assign bus.commit_pend = r_commit_pend;
   assign bus.commit_done = r_commit_done;
   assign bus.frame_start = r_frame_start;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: a cycle-number based display model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_seven_seg_scan_driver;
   localparam int N     = 6;
   localparam int P     = 4;
   localparam int BW    = 4;
   localparam int IW    = $clog2(N);
   localparam int T     = 1 << BW;
   localparam int PER   = T * P;
   localparam int FRAME = N * PER;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   compareOn = 1'b0;

   seven_seg_scan_driver_if #(.NUM_DIGITS(N), .BRIGHT_W(BW)) bus ();

   seven_seg_scan_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BRIGHT_W(BW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       mode;
      bit [7:0] data;
      bit       dp;
   } ent_t;

   ent_t         mShadow [N];
   ent_t         mActive [N];
   bit           mPend;
   int           cyc;
   logic [N-1:0] expAn;
   logic [6:0]   expSeg;
   logic         expDp;
   logic         expDone;
   logic         expFrame;
   logic [6:0]   hexTab [16];
   logic [6:0]   asciiTab [256];

   task automatic buildTables();
      string      letters;
      logic [6:0] vals [25];
      hexTab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                 7'h7F, 7'h73, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};
      for (int i = 0; i < 256; i++) asciiTab[i] = 7'h00;
      for (int d = 0; d < 10; d++) asciiTab[8'h30 + d] = hexTab[d];
      asciiTab[8'h3A] = 7'h77;
      asciiTab[8'h3B] = 7'h1F;
      asciiTab[8'h3C] = 7'h0D;
      asciiTab[8'h3D] = 7'h3D;
      asciiTab[8'h3E] = 7'h4F;
      asciiTab[8'h3F] = 7'h47;
      asciiTab[8'h2D] = 7'h01;
      letters = "AabCcdEFGHhIJLnOoPqrStUuy";
      vals = '{7'h77, 7'h7D, 7'h1F, 7'h4E, 7'h0D, 7'h3D, 7'h4F, 7'h47, 7'h5E, 7'h37,
               7'h17, 7'h06, 7'h3C, 7'h0E, 7'h15, 7'h7E, 7'h1D, 7'h67, 7'h73, 7'h05,
               7'h5B, 7'h0F, 7'h3E, 7'h1C, 7'h3B};
      for (int i = 0; i < 25; i++) asciiTab[letters[i]] = vals[i];
   endtask

   task automatic modelReset();
      for (int i = 0; i < N; i++) begin
         mShadow[i] = '{1'b1, 8'h20, 1'b0};
         mActive[i] = '{1'b1, 8'h20, 1'b0};
      end
      mPend    = 1'b0;
      cyc      = 0;
      expAn    = '1;
      expSeg   = 7'h7F;
      expDp    = 1'b1;
      expDone  = 1'b0;
      expFrame = 1'b0;
   endtask

   // Scan position follows from the cycle number since reset release.
   task automatic modelStep();
      int         dig;
      int         tick;
      bit         lit;
      bit         wrap;
      bit         copy;
      logic [6:0] g;
      dig  = (cyc / PER) % N;
      tick = (cyc / P) % T;
      lit  = (tick < int'(bus.brightness)) && !bus.blank_mask[dig];
      g    = mActive[dig].mode ? asciiTab[mActive[dig].data] : hexTab[mActive[dig].data[3:0]];
      expAn  = lit ? ~(N'(1) << dig) : '1;
      expSeg = lit ? ~g : 7'h7F;
      expDp  = !(lit && mActive[dig].dp);
      wrap = (cyc % FRAME) == FRAME - 1;
      copy = wrap && mPend;
      expDone  = copy;
      expFrame = wrap;
      if (copy) mActive = mShadow;
      if (bus.wr_en && int'(bus.wr_idx) < N) mShadow[bus.wr_idx] = '{bus.wr_mode, bus.wr_data, bus.wr_dp};
      mPend = (mPend && !copy) || bus.commit;
      cyc++;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else modelStep();
   end

   always @(negedge clk) begin
      if (compareOn) begin
         checks++;
         if (bus.an_n !== expAn || bus.seg_n !== expSeg || bus.dp_n !== expDp ||
             bus.commit_pend !== mPend || bus.commit_done !== expDone || bus.frame_start !== expFrame) begin
            errors++;
            $display("[TB] FAIL cycleModel cyc=%0d got an_n=%b seg_n=%h dp_n=%b pend=%b done=%b frame=%b expected an_n=%b seg_n=%h dp_n=%b pend=%b done=%b frame=%b",
                     cyc, bus.an_n, bus.seg_n, bus.dp_n, bus.commit_pend, bus.commit_done, bus.frame_start,
                     expAn, expSeg, expDp, mPend, expDone, expFrame);
         end
      end
   end

   task automatic checkOutput(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("[TB] FAIL %s got 0x%0h expected 0x%0h (cyc=%0d)", name, got, want, cyc);
      end
   endtask

   // Called at a negedge; drives one write (optionally with commit) for exactly one cycle.
   task automatic applyStimulus(input int idx, input bit mode, input logic [7:0] data,
                                input bit dp, input bit doCommit);
      bus.wr_en   = 1'b1;
      bus.wr_idx  = IW'(idx);
      bus.wr_mode = mode;
      bus.wr_data = data;
      bus.wr_dp   = dp;
      bus.commit  = doCommit;
      @(negedge clk);
      bus.wr_en  = 1'b0;
      bus.commit = 1'b0;
   endtask

   task automatic commitPulse();
      bus.commit = 1'b1;
      @(negedge clk);
      bus.commit = 1'b0;
   endtask

   task automatic waitDone(input string name);
      for (int k = 0; k < 2 * FRAME + 4; k++) begin
         if (bus.commit_done === 1'b1) break;
         @(negedge clk);
      end
      checkOutput({name, " commit_done seen"}, int'(bus.commit_done === 1'b1), 1);
   endtask

   task automatic waitLit(input int d);
      logic [N-1:0] want;
      want = ~(N'(1) << d);
      for (int k = 0; k < FRAME + 4; k++) begin
         if (bus.an_n === want) break;
         @(negedge clk);
      end
      checkOutput("digit lit within a frame", int'(bus.an_n === want), 1);
   endtask

   task automatic waitUntilCyc(input int target);
      for (int k = 0; k < 2 * FRAME && cyc < target; k++) @(negedge clk);
      checkOutput("reached target cycle", cyc, target);
   endtask

   initial begin
      #2_000_000;
      errors++;
      $display("[TB] FAIL watchdog simulation did not complete");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      int         darkCnt;
      int         onCnt;
      int         target;
      int         brightVals [3];
      int         onWant [3];
      logic [7:0] pinCode [4];
      logic [6:0] pinSeg [4];

      buildTables();
      bus.wr_en      = 1'b0;
      bus.wr_idx     = '0;
      bus.wr_mode    = 1'b0;
      bus.wr_data    = 8'h00;
      bus.wr_dp      = 1'b0;
      bus.commit     = 1'b0;
      bus.brightness = '0;
      bus.blank_mask = '0;
      rst_n          = 1'b0;

      @(posedge clk);
      compareOn = 1'b1;
      @(negedge clk);
      checkOutput("reset an_n", bus.an_n, 6'h3F);
      checkOutput("reset seg_n", bus.seg_n, 7'h7F);
      checkOutput("reset dp_n", bus.dp_n, 1);
      checkOutput("reset commit_pend", bus.commit_pend, 0);
      #2 rst_n = 1'b1;

      // Idle with brightness 0, then the commit at cycle 10.
      darkCnt = 0;
      @(negedge clk);
      while (cyc < 10) @(negedge clk);
      checkOutput("commit_pend before commit", bus.commit_pend, 0);
      applyStimulus(0, 1'b0, 8'h0A, 1'b0, 1'b1);
      checkOutput("commit_pend at cycle 11", bus.commit_pend, 1);
      for (int k = 0; k < FRAME && bus.frame_start !== 1'b1; k++) begin
         if (bus.an_n !== 6'h3F || bus.seg_n !== 7'h7F) darkCnt++;
         @(negedge clk);
      end
      checkOutput("first frame_start cycle", cyc, 384);
      checkOutput("commit_done with frame_start", bus.commit_done, 1);
      checkOutput("idle display dark", darkCnt, 0);
      checkOutput("commit_pend cleared", bus.commit_pend, 0);
      bus.brightness = 4'd8;
      @(negedge clk);
      checkOutput("digit0 anode", bus.an_n, 6'h3E);
      checkOutput("digit0 hex A", bus.seg_n, 7'h08);

      // PWM duty per digit over one full frame.
      brightVals = '{5, 15, 0};
      onWant     = '{20, 60, 0};
      for (int b = 0; b < 3; b++) begin
         bus.brightness = BW'(brightVals[b]);
         @(negedge clk);
         onCnt = 0;
         repeat (FRAME) begin
            if (bus.an_n[2] === 1'b0) onCnt++;
            @(negedge clk);
         end
         checkOutput("digit2 on-cycles per frame", onCnt, onWant[b]);
      end
      bus.brightness = 4'd5;
      bus.blank_mask = 6'b000010;
      @(negedge clk);
      onCnt   = 0;
      darkCnt = 0;
      repeat (FRAME) begin
         if (bus.an_n[1] === 1'b0) darkCnt++;
         if (bus.an_n[2] === 1'b0) onCnt++;
         @(negedge clk);
      end
      checkOutput("blanked digit1 never lit", darkCnt, 0);
      checkOutput("digit2 unaffected by blank", onCnt, 20);
      bus.blank_mask = '0;
      bus.brightness = 4'd8;

      // ASCII sweep of all 256 codes, N codes per committed frame.
      for (int base = 0; base < 256; base += N) begin
         for (int k = 0; k < N; k++) begin
            int code;
            code = base + k;
            if (code > 255) code = 8'h20;
            applyStimulus(k, 1'b1, code[7:0], code[0], k == N - 1);
         end
         waitDone("ascii batch");
      end
      repeat (FRAME) @(negedge clk);

      // Literal glyph pins on digit 3 with the decimal point set.
      pinCode = '{8'h48, 8'h2D, 8'h7A, 8'h3B};
      pinSeg  = '{7'h48, 7'h7E, 7'h7F, 7'h60};
      for (int i = 0; i < 4; i++) begin
         applyStimulus(3, 1'b1, pinCode[i], 1'b1, 1'b1);
         waitDone("digit3 pin");
         waitLit(3);
         checkOutput("digit3 ascii seg_n", bus.seg_n, pinSeg[i]);
         checkOutput("digit3 dp_n lit", bus.dp_n, 0);
      end

      // Write landing in the copy cycle stays in the shadow until the next commit.
      applyStimulus(2, 1'b0, 8'h01, 1'b0, 1'b1);
      waitDone("idx2 first");
      applyStimulus(2, 1'b0, 8'h02, 1'b0, 1'b1);
      target = ((cyc / FRAME) + 1) * FRAME - 1;
      waitUntilCyc(target);
      applyStimulus(2, 1'b0, 8'h03, 1'b0, 1'b0);
      checkOutput("copy-cycle commit_done", bus.commit_done, 1);
      waitLit(2);
      checkOutput("copy used pre-write shadow", bus.seg_n, 7'h12);
      commitPulse();
      waitDone("idx2 second");
      waitLit(2);
      checkOutput("later commit shows new idx2", bus.seg_n, 7'h06);
      applyStimulus(7, 1'b0, 8'h08, 1'b0, 1'b0);
      applyStimulus(6, 1'b0, 8'h08, 1'b0, 1'b1);
      waitDone("out-of-range writes");
      waitLit(0);
      checkOutput("digit0 unchanged", bus.seg_n, 7'h7F);
      waitLit(2);
      checkOutput("digit2 unchanged", bus.seg_n, 7'h06);

      // Reset mid-frame while a commit is pending.
      applyStimulus(0, 1'b0, 8'h07, 1'b0, 1'b1);
      repeat (100) @(negedge clk);
      checkOutput("pend before reset", bus.commit_pend, 1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset an_n immediate", bus.an_n, 6'h3F);
      checkOutput("reset seg_n immediate", bus.seg_n, 7'h7F);
      checkOutput("reset pend immediate", bus.commit_pend, 0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      waitLit(0);
      checkOutput("digit0 blank after reset", bus.seg_n, 7'h7F);
      checkOutput("pend after reset", bus.commit_pend, 0);
      waitLit(2);
      checkOutput("digit2 blank after reset", bus.seg_n, 7'h7F);

      repeat (4) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
